// File: rtl/ct_rtu_iid_pkg.sv
// Shared IID age helpers for the RTU oldest-entry trackers.
// The wrap-aware age compare lives here so the tree nodes and the held-entry
// merge use one definition.
package ct_rtu_iid_pkg;

    localparam int IID_W_DEF  = 7;
    localparam int INFO_W_DEF = 8;
    localparam int CH_W_DEF   = 2;

    // Candidate record at the default configuration (7-bit IID, 8-bit payload, 4 channels).
    typedef struct packed {
        logic                  vld;
        logic [IID_W_DEF-1:0]  iid;
        logic [INFO_W_DEF-1:0] info;
        logic [CH_W_DEF-1:0]   ch;
    } cand_t;

    // True when a is strictly older than b for a w-bit IID whose MSB is the wrap bit.
    // Equal MSBs: smaller low part is older. Differing MSBs: the older entry is on
    // the previous lap, so the larger low part is older.
    function automatic logic iid_older(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [31:0] mask;
        logic        ma;
        logic        mb;
        mask = (32'd1 << (w - 1)) - 32'd1;
        ma   = ((a >> (w - 1)) & 32'd1) != 32'd0;
        mb   = ((b >> (w - 1)) & 32'd1) != 32'd0;
        if (ma == mb) begin
            return (a & mask) < (b & mask);
        end
        return (a & mask) > (b & mask);
    endfunction

endpackage

// File: rtl/ct_rtu_iid_cmp_node.sv
// Two-input node of the oldest-candidate selection tree.
// Invalid inputs lose to valid ones; equal IIDs resolve to the lower channel
// number, which keeps the tie rule correct even when the tree is unbalanced.
module ct_rtu_iid_cmp_node
    import ct_rtu_iid_pkg::*;
#(
    parameter int IID_W  = IID_W_DEF,
    parameter int INFO_W = INFO_W_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic              a_vld,
    input  logic [IID_W-1:0]  a_iid,
    input  logic [INFO_W-1:0] a_info,
    input  logic [CH_W-1:0]   a_ch,
    input  logic              b_vld,
    input  logic [IID_W-1:0]  b_iid,
    input  logic [INFO_W-1:0] b_info,
    input  logic [CH_W-1:0]   b_ch,
    output logic              y_vld,
    output logic [IID_W-1:0]  y_iid,
    output logic [INFO_W-1:0] y_info,
    output logic [CH_W-1:0]   y_ch
);

    logic b_wins;

    // b only wins when it is valid and either a is empty, b is older, or it ties from a lower channel
    always_comb begin
        b_wins = b_vld && (!a_vld
                           || iid_older(32'(b_iid), 32'(a_iid), IID_W)
                           || ((b_iid == a_iid) && (b_ch < a_ch)));
        y_vld  = a_vld | b_vld;
        y_iid  = b_wins ? b_iid  : a_iid;
        y_info = b_wins ? b_info : a_info;
        y_ch   = b_wins ? b_ch   : a_ch;
    end

endmodule

// File: rtl/ct_rtu_oldest_iid_track.sv
// Tracks the oldest pending (IID, payload) across NUM_CH candidate channels.
// A comparator tree picks the oldest valid candidate each cycle; the winner is
// merged into a single held entry that lives until retired or flushed.
// Optional macro CT_RTU_OLDEST_IID_PIPE_EN registers the tree output before the
// merge (2-cycle latency); without it the merge is fed combinationally.
module ct_rtu_oldest_iid_track
    import ct_rtu_iid_pkg::*;
#(
    parameter  int IID_W  = IID_W_DEF,
    parameter  int NUM_CH = 4,
    parameter  int INFO_W = INFO_W_DEF,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic [NUM_CH-1:0]        x_vld,
    input  logic [NUM_CH*IID_W-1:0]  x_iid,
    input  logic [NUM_CH*INFO_W-1:0] x_info,
    input  logic                     rtu_flush,
    input  logic                     rtu_retire_vld,
    input  logic [IID_W-1:0]         rtu_retire_iid,
    output logic                     oldest_vld,
    output logic [IID_W-1:0]         oldest_iid,
    output logic [INFO_W-1:0]        oldest_info,
    output logic [CH_W-1:0]          oldest_ch
);

    // Heap-ordered tree: node i has children 2i+1 and 2i+2; leaves start at NUM_CH-1.
    localparam int NODES = 2 * NUM_CH - 1;

    logic              t_vld  [NODES];
    logic [IID_W-1:0]  t_iid  [NODES];
    logic [INFO_W-1:0] t_info [NODES];
    logic [CH_W-1:0]   t_ch   [NODES];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_leaf
        assign t_vld[NUM_CH-1+k]  = x_vld[k];
        assign t_iid[NUM_CH-1+k]  = x_iid[k*IID_W +: IID_W];
        assign t_info[NUM_CH-1+k] = x_info[k*INFO_W +: INFO_W];
        assign t_ch[NUM_CH-1+k]   = CH_W'(k);
    end

    for (genvar i = 0; i < NUM_CH - 1; i++) begin : g_node
        ct_rtu_iid_cmp_node #(
            .IID_W  (IID_W),
            .INFO_W (INFO_W),
            .CH_W   (CH_W)
        ) u_node (
            .a_vld  (t_vld[2*i+1]),
            .a_iid  (t_iid[2*i+1]),
            .a_info (t_info[2*i+1]),
            .a_ch   (t_ch[2*i+1]),
            .b_vld  (t_vld[2*i+2]),
            .b_iid  (t_iid[2*i+2]),
            .b_info (t_info[2*i+2]),
            .b_ch   (t_ch[2*i+2]),
            .y_vld  (t_vld[i]),
            .y_iid  (t_iid[i]),
            .y_info (t_info[i]),
            .y_ch   (t_ch[i])
        );
    end

    // Candidate presented to the merge
    logic              m_vld;
    logic [IID_W-1:0]  m_iid;
    logic [INFO_W-1:0] m_info;
    logic [CH_W-1:0]   m_ch;

`ifdef CT_RTU_OLDEST_IID_PIPE_EN
    logic              stg_vld_q;
    logic [IID_W-1:0]  stg_iid_q;
    logic [INFO_W-1:0] stg_info_q;
    logic [CH_W-1:0]   stg_ch_q;

    // Stage the tree winner; a flush empties the stage so nothing in flight survives it
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            stg_vld_q  <= 1'b0;
            stg_iid_q  <= '0;
            stg_info_q <= '0;
            stg_ch_q   <= '0;
        end else begin
            stg_vld_q  <= t_vld[0] && !rtu_flush;
            stg_iid_q  <= t_iid[0];
            stg_info_q <= t_info[0];
            stg_ch_q   <= t_ch[0];
        end
    end

    assign m_vld  = stg_vld_q;
    assign m_iid  = stg_iid_q;
    assign m_info = stg_info_q;
    assign m_ch   = stg_ch_q;
`else
    assign m_vld  = t_vld[0];
    assign m_iid  = t_iid[0];
    assign m_info = t_info[0];
    assign m_ch   = t_ch[0];
`endif

    logic              oldest_vld_q,  oldest_vld_d;
    logic [IID_W-1:0]  oldest_iid_q,  oldest_iid_d;
    logic [INFO_W-1:0] oldest_info_q, oldest_info_d;
    logic [CH_W-1:0]   oldest_ch_q,   oldest_ch_d;
    logic              held_live;
    logic              take;

    // Merge: a matching retire empties the held entry before the candidate is considered
    always_comb begin
        held_live     = oldest_vld_q && !(rtu_retire_vld && (rtu_retire_iid == oldest_iid_q));
        take          = m_vld && (!held_live || iid_older(32'(m_iid), 32'(oldest_iid_q), IID_W));
        oldest_vld_d  = held_live;
        oldest_iid_d  = oldest_iid_q;
        oldest_info_d = oldest_info_q;
        oldest_ch_d   = oldest_ch_q;
        if (rtu_flush) begin
            oldest_vld_d = 1'b0;
        end else if (take) begin
            oldest_vld_d  = 1'b1;
            oldest_iid_d  = m_iid;
            oldest_info_d = m_info;
            oldest_ch_d   = m_ch;
        end
    end

    // Held oldest entry
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            oldest_vld_q  <= 1'b0;
            oldest_iid_q  <= '0;
            oldest_info_q <= '0;
            oldest_ch_q   <= '0;
        end else begin
            oldest_vld_q  <= oldest_vld_d;
            oldest_iid_q  <= oldest_iid_d;
            oldest_info_q <= oldest_info_d;
            oldest_ch_q   <= oldest_ch_d;
        end
    end

    assign oldest_vld  = oldest_vld_q;
    assign oldest_iid  = oldest_iid_q;
    assign oldest_info = oldest_info_q;
    assign oldest_ch   = oldest_ch_q;

endmodule

// File: tb/tb_ct_rtu_oldest_iid_track.sv
// Bench for ct_rtu_oldest_iid_track (IID_W=7, NUM_CH=4, INFO_W=8).
// Reference model: age from modular distance, oldest pick by a linear scan.
module tb_ct_rtu_oldest_iid_track;

    localparam int IID_W  = 7;
    localparam int NUM_CH = 4;
    localparam int INFO_W = 8;
    localparam int IMASK  = (1 << IID_W) - 1;

    logic                     clk = 1'b0;
    logic                     cpurst;
    logic [NUM_CH-1:0]        x_vld;
    logic [NUM_CH*IID_W-1:0]  x_iid;
    logic [NUM_CH*INFO_W-1:0] x_info;
    logic                     rtu_flush;
    logic                     rtu_retire_vld;
    logic [IID_W-1:0]         rtu_retire_iid;
    logic                     oldest_vld;
    logic [IID_W-1:0]         oldest_iid;
    logic [INFO_W-1:0]        oldest_info;
    logic [1:0]               oldest_ch;

    int total = 0;
    int bad   = 0;

    ct_rtu_oldest_iid_track #(.IID_W(IID_W), .NUM_CH(NUM_CH), .INFO_W(INFO_W)) dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .x_vld          (x_vld),
        .x_iid          (x_iid),
        .x_info         (x_info),
        .rtu_flush      (rtu_flush),
        .rtu_retire_vld (rtu_retire_vld),
        .rtu_retire_iid (rtu_retire_iid),
        .oldest_vld     (oldest_vld),
        .oldest_iid     (oldest_iid),
        .oldest_info    (oldest_info),
        .oldest_ch      (oldest_ch)
    );

    always #5 clk = ~clk;

    // Reference state
    bit         m_vld;
    logic [6:0] m_iid;
    logic [7:0] m_info;
    logic [1:0] m_ch;
`ifdef CT_RTU_OLDEST_IID_PIPE_EN
    bit         s_vld;
    logic [6:0] s_iid;
    logic [7:0] s_info;
    logic [1:0] s_ch;
`endif

    // a is older than b when b lies 1..2^(W-1)-1 steps after a, modulo 2^W
    function automatic bit older_m(input int a, input int b);
        int d;
        d = (b - a) & IMASK;
        return (d > 0) && (d < (1 << (IID_W - 1)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [6:0] iid, input logic [7:0] info);
        x_vld[k]               = 1'b1;
        x_iid[k*IID_W +: IID_W]   = iid;
        x_info[k*INFO_W +: INFO_W] = info;
    endtask

    task automatic clear_in();
        x_vld          = '0;
        rtu_flush      = 1'b0;
        rtu_retire_vld = 1'b0;
        rtu_retire_iid = '0;
        cpurst         = 1'b0;
    endtask

    // Advance one clock: predict from the current inputs, then compare after the edge
    task automatic step();
        bit         sv;
        logic [6:0] si;
        logic [7:0] sinfo;
        logic [1:0] sc;
        bit         mv;
        logic [6:0] mi;
        logic [7:0] minfo;
        logic [1:0] mc;
        bit         hl;
        bit         was_rst;
        sv = 0; si = '0; sinfo = '0; sc = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (x_vld[k] && (!sv || older_m(int'(x_iid[k*IID_W +: IID_W]), int'(si)))) begin
                sv    = 1;
                si    = x_iid[k*IID_W +: IID_W];
                sinfo = x_info[k*INFO_W +: INFO_W];
                sc    = 2'(k);
            end
        end
        if (rtu_flush) sv = 0;
`ifdef CT_RTU_OLDEST_IID_PIPE_EN
        mv = s_vld; mi = s_iid; minfo = s_info; mc = s_ch;
`else
        mv = sv; mi = si; minfo = sinfo; mc = sc;
`endif
        hl = m_vld && !(rtu_retire_vld && (rtu_retire_iid == m_iid));
        was_rst = cpurst;
        if (cpurst) begin
            m_vld = 0; m_iid = '0; m_info = '0; m_ch = '0;
        end else if (rtu_flush) begin
            m_vld = 0;
        end else if (mv && (!hl || older_m(int'(mi), int'(m_iid)))) begin
            m_vld = 1; m_iid = mi; m_info = minfo; m_ch = mc;
        end else begin
            m_vld = hl;
        end
`ifdef CT_RTU_OLDEST_IID_PIPE_EN
        if (cpurst) begin
            s_vld = 0; s_iid = '0; s_info = '0; s_ch = '0;
        end else begin
            s_vld = sv; s_iid = si; s_info = sinfo; s_ch = sc;
        end
`endif
        @(posedge clk);
        #1;
        chk("model_vld", 32'(oldest_vld), 32'(m_vld));
        if (m_vld || was_rst) begin
            chk("model_iid",  32'(oldest_iid),  32'(m_iid));
            chk("model_info", 32'(oldest_info), 32'(m_info));
            chk("model_ch",   32'(oldest_ch),   32'(m_ch));
        end
    endtask

    // Apply the current inputs for one cycle, then idle long enough for any pipeline to drain
    task automatic settle();
        step();
        clear_in();
        step();
    endtask

    int base;

    initial begin
        x_iid = '0; x_info = '0;
        m_vld = 0; m_iid = '0; m_info = '0; m_ch = '0;
`ifdef CT_RTU_OLDEST_IID_PIPE_EN
        s_vld = 0; s_iid = '0; s_info = '0; s_ch = '0;
`endif
        clear_in();
        cpurst = 1'b1;
        step();
        clear_in();
        step();
        chk("idle_vld",  32'(oldest_vld),  32'd0);
        chk("idle_iid",  32'(oldest_iid),  32'd0);
        chk("idle_info", 32'(oldest_info), 32'd0);
        chk("idle_ch",   32'(oldest_ch),   32'd0);

        // Two candidates, lower IID wins
        set_ch(0, 7'h05, 8'h11); set_ch(1, 7'h03, 8'h22);
        settle();
        chk("first_vld", 32'(oldest_vld), 32'd1);
        chk("first_iid", 32'(oldest_iid), 32'h03);
        chk("first_ch",  32'(oldest_ch),  32'd1);

        // Retire 0x03 while offering 0x01 -> held 0x01
        rtu_retire_vld = 1'b1; rtu_retire_iid = 7'h03; set_ch(0, 7'h01, 8'h33);
        settle();
        chk("held01_iid", 32'(oldest_iid), 32'h01);

        // Wrap: 0x7E is on the previous lap, so older than 0x01
        set_ch(2, 7'h7E, 8'h44);
        settle();
        chk("wrap_iid", 32'(oldest_iid), 32'h7E);
        chk("wrap_ch",  32'(oldest_ch),  32'd2);

        // Tie between ch1 and ch3 into an empty entry
        rtu_flush = 1'b1;
        settle();
        set_ch(1, 7'h10, 8'hAA); set_ch(3, 7'h10, 8'hBB);
        settle();
        chk("tie_ch",   32'(oldest_ch),   32'd1);
        chk("tie_info", 32'(oldest_info), 32'hAA);
        set_ch(0, 7'h10, 8'hCC);
        settle();
        chk("tie_hold_ch",   32'(oldest_ch),   32'd1);
        chk("tie_hold_info", 32'(oldest_info), 32'hAA);

        // Retire and capture together
        rtu_retire_vld = 1'b1; rtu_retire_iid = 7'h10; set_ch(0, 7'h20, 8'h55);
        settle();
        chk("held20_iid", 32'(oldest_iid), 32'h20);
        rtu_retire_vld = 1'b1; rtu_retire_iid = 7'h20; set_ch(0, 7'h30, 8'h66);
        settle();
        chk("retcap_iid", 32'(oldest_iid), 32'h30);
        rtu_retire_vld = 1'b1; rtu_retire_iid = 7'h21;
        settle();
        chk("retmiss_vld", 32'(oldest_vld), 32'd1);
        chk("retmiss_iid", 32'(oldest_iid), 32'h30);

        // Flush with all channels valid
        set_ch(0, 7'h08, 8'h77);
        settle();
        chk("held08_iid", 32'(oldest_iid), 32'h08);
        rtu_flush = 1'b1;
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 7'(8'h04 + k), 8'(k));
        step();
        chk("flush_vld", 32'(oldest_vld), 32'd0);
        clear_in();
        for (int n = 0; n < 3; n++) begin
            step();
            chk("flush_idle_vld", 32'(oldest_vld), 32'd0);
        end

        // Latency from x_vld to oldest_vld
        set_ch(0, 7'h04, 8'h99);
        step();
        clear_in();
`ifdef CT_RTU_OLDEST_IID_PIPE_EN
        chk("lat_t1_vld", 32'(oldest_vld), 32'd0);
        step();
        chk("lat_t2_vld", 32'(oldest_vld), 32'd1);
        rtu_flush = 1'b1;
        settle();
        set_ch(0, 7'h04, 8'h99);
        step();
        clear_in();
        rtu_flush = 1'b1;
        step();
        clear_in();
        chk("pipe_flush_t1", 32'(oldest_vld), 32'd0);
        step();
        chk("pipe_flush_t2", 32'(oldest_vld), 32'd0);
        set_ch(0, 7'h04, 8'h99);
        settle();
`else
        chk("lat_t1_vld", 32'(oldest_vld), 32'd1);
        step();
`endif

        // One-cycle reset mid-operation with candidates present
        cpurst = 1'b1;
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 7'(8'h02 + k), 8'(8'hF0 + k));
        step();
        chk("midrst_vld", 32'(oldest_vld), 32'd0);
        chk("midrst_iid", 32'(oldest_iid), 32'd0);
        clear_in();
        step();
        chk("midrst_after_vld", 32'(oldest_vld), 32'd0);

        // Random traffic inside a sliding IID window
        base = 0;
        for (int n = 0; n < 600; n++) begin
            clear_in();
            base = (base + int'($urandom_range(0, 1))) & IMASK;
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 1) == 1)
                    set_ch(k, 7'((base + int'($urandom_range(0, 23))) & IMASK), 8'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                rtu_retire_vld = 1'b1;
                rtu_retire_iid = (m_vld && $urandom_range(0, 1) == 1) ? m_iid
                               : 7'((base + int'($urandom_range(0, 23))) & IMASK);
            end
            if (m_vld && (((base - int'(m_iid)) & IMASK) > 30) && (((base - int'(m_iid)) & IMASK) < 64)) begin
                rtu_retire_vld = 1'b1;
                rtu_retire_iid = m_iid;
            end
            rtu_flush = ($urandom_range(0, 24) == 0);
            step();
        end
        clear_in();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ct_rtu_oldest_iid_track.md
Name: ct_rtu_oldest_iid_track

Overview:
- Parametrised, sequential successor to the fixed 7-bit two-input IID age comparator.
- Each cycle, accepts up to NUM_CH valid (IID, payload) candidates and selects the oldest through a comparator tree.
- Merges the winner into a single held "oldest pending" entry that persists until retired or flushed.
- Sits in RTU; used for oldest-exception and oldest-split-request tracking.

Parameters:
- IID_W, 7, IID width; MSB is the wrap bit; must be ≥ 2.
- NUM_CH, 4, number of candidate channels (1..8).
- INFO_W, 8, payload width carried with each IID.

Ports:
- forever_cpuclk  input  1  clock.
- cpurst  input  1  synchronous, active-high reset.
- x_vld  input  NUM_CH  per-channel candidate valid.
- x_iid  input  NUM_CH*IID_W  candidate IIDs; channel k occupies bits [k*IID_W +: IID_W].
- x_info  input  NUM_CH*INFO_W  candidate payloads; same packing as x_iid.
- rtu_flush  input  1  clear the held entry and drop all candidates this cycle.
- rtu_retire_vld  input  1  retire event.
- rtu_retire_iid  input  IID_W  IID being retired.
- oldest_vld  output  1  held entry valid.
- oldest_iid  output  IID_W  held IID.
- oldest_info  output  INFO_W  held payload.
- oldest_ch  output  $clog2(NUM_CH) (min 1)  source channel of the held entry.

Behaviour:
- Age rule, a older than b:
  - If the MSBs are equal, a[IID_W-2:0] < b[IID_W-2:0].
  - If the MSBs differ, a[IID_W-2:0] > b[IID_W-2:0].
  - Equal IIDs: not older.
- Selection tree:
  - Binary tree of age comparators over the valid channels.
  - Invalid leaves lose to any valid leaf.
  - Ties (equal IID) go to the lower channel index.
  - Tree outputs cand_vld, cand_iid, cand_info, cand_ch.
- Held-entry update, in this priority order, registered on forever_cpuclk:
  1. cpurst: oldest_vld=0; oldest_iid, oldest_info and oldest_ch all 0.
  2. rtu_flush: oldest_vld=0; candidates this cycle are discarded.
  3. Retire clears: rtu_retire_vld && oldest_vld && rtu_retire_iid==oldest_iid → held entry treated as empty for the rest of this cycle's evaluation.
  4. Capture: cand_vld && (held empty || cand older than held) → capture the candidate.
  5. Otherwise hold.
- Retire and a new candidate in the same cycle: the retire clears first, so the candidate is captured regardless of age versus the retired entry.
- Retire with a non-matching IID: no effect.
- Latency: x_vld to oldest_vld is 1 cycle. Outputs are driven directly from flops.
- Data fields when oldest_vld=0: hold their last value; the bench must not check them.
- No backpressure. Candidates are fire-and-forget; a candidate that loses is dropped.
- Wrap-around: correct provided live IIDs span fewer than 2^(IID_W-1) entries. This is a caller guarantee and is not checked.
- Reset mid-operation: a one-cycle cpurst clears all state, including the pipeline stage below.

Optional Feature:
- Macro: CT_RTU_OLDEST_IID_PIPE_EN.
- Defined:
  - Tree output is registered (cand stage) before the merge, for timing at large NUM_CH. Latency becomes 2 cycles.
  - rtu_flush also clears the staged candidate.
  - Retire compares only against the held entry; a staged candidate is merged on the next cycle.
- Undefined: the tree feeds the merge combinationally; latency is 1 cycle.

Decomposition:
- Package ct_rtu_iid_pkg:
  - IID_W default.
  - Function iid_older(a, b), implementing the age rule.
  - Typedef of the candidate struct {vld, iid, info, ch}.
- Sub-module ct_rtu_iid_cmp_node:
  - Parametrised two-input tree node: valid-aware oldest select with tie-to-lower-index.
  - Instantiated NUM_CH-1 times via generate.

Test Plan (IID_W=7, NUM_CH=4, feature off unless stated):
- Reset, then idle → oldest_vld=0 and all outputs 0. Then x_vld=4'b0011, iid ch0=0x05, ch1=0x03 → next cycle: oldest_vld=1, oldest_iid=0x03, oldest_ch=1.
- Wrap case: held=0x01; x_vld=4'b0100, ch2 iid=0x7E → 0x7E older (MSB differs, 0x3E > 0x01) → oldest_iid=0x7E, oldest_ch=2.
- Tie: ch1 and ch3 both iid=0x10 with info 0xAA/0xBB, held empty → oldest_ch=1, oldest_info=0xAA. Next cycle ch0 iid=0x10 → held unchanged.
- Retire and capture together: held=0x20; rtu_retire_vld=1, iid=0x20; same cycle ch0 iid=0x30 → oldest_iid=0x30. A retire with iid=0x21 against held 0x30 → no change.
- Flush and inputs together: held=0x08; rtu_flush=1 with x_vld=4'b1111 → oldest_vld=0 next cycle, then stays 0 while inputs are idle.
- PIPE_EN: ch0 iid=0x04 at cycle t → oldest_vld rises at t+2. rtu_flush at t+1 → oldest_vld stays 0.
